// File: rtl/rr_decode_arbiter_pkg.sv
// Shared types and constants for the round-robin decode arbiter.
package rr_arb_pkg;

  localparam int NREQ_DEF  = 16;
  localparam int IDX_W_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Deasserted select pattern: every active-low line high.
  localparam logic [NREQ_DEF-1:0] GNT_IDLE = '1;

endpackage

// File: rtl/rr_decode_arbiter_prio_pick.sv
// Rotating priority encoder: first set request searching upward from
// last+1, wrapping modulo NREQ (NREQ is a power of two, so index
// arithmetic wraps for free).
module rr_prio_pick #(
  parameter int NREQ  = 16,
  parameter int IDX_W = 4
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [IDX_W-1:0] pick_o,
  output logic             any_o
);

  logic [IDX_W-1:0] cand;

  // Walk from lowest to highest priority so the final hit wins.
  always_comb begin
    pick_o = '0;
    any_o  = 1'b0;
    cand   = '0;
    for (int i = NREQ; i >= 1; i--) begin
      cand = last_i + IDX_W'(i);
      if (req_i[cand]) begin
        pick_o = cand;
        any_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter with an active-low one-hot grant for driving
// chip-select lines. Optional forced release after MAX_HOLD busy cycles
// is enabled by defining RR_DECODE_ARBITER_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no grant held; arbitrates when en=1 and any req is set
// BUSY  | grant held for gnt_idx until its req drops (or hold limit)
module rr_decode_arbiter
  import rr_arb_pkg::*;
#(
  parameter int NREQ     = NREQ_DEF,
  parameter int IDX_W    = IDX_W_DEF,
  parameter int MAX_HOLD = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt_n,
  output logic             gnt_vld,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             timeout
);

  state_e           state_q;
  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] gnt_idx_q;
  logic [NREQ-1:0]  gnt_n_q;
  logic [NREQ-1:0]  gnt_n_d;
  logic             gnt_vld_q;
  logic [IDX_W-1:0] pick;
  logic             any;
  logic             owner_req;
  logic             hold_expire;

`ifdef RR_DECODE_ARBITER_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] hold_cnt_q;
  logic              timeout_q;
  assign hold_expire = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
  assign timeout     = timeout_q;
`else
  assign hold_expire = 1'b0;
  assign timeout     = 1'b0;
`endif

  rr_prio_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i  (req),
    .last_i (last_q),
    .pick_o (pick),
    .any_o  (any)
  );

  assign owner_req = req[gnt_idx_q];

  // Decode the winning index into the active-low one-hot select.
  always_comb begin
    gnt_n_d       = GNT_IDLE[NREQ-1:0];
    gnt_n_d[pick] = 1'b0;
  end

  // Grant FSM, pointer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= IDX_W'(NREQ - 1);
      gnt_idx_q  <= '0;
      gnt_n_q    <= GNT_IDLE[NREQ-1:0];
      gnt_vld_q  <= 1'b0;
`ifdef RR_DECODE_ARBITER_TIMEOUT_EN
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
`ifdef RR_DECODE_ARBITER_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (en && any) begin
            state_q    <= BUSY;
            gnt_idx_q  <= pick;
            last_q     <= pick;
            gnt_n_q    <= gnt_n_d;
            gnt_vld_q  <= 1'b1;
`ifdef RR_DECODE_ARBITER_TIMEOUT_EN
            hold_cnt_q <= '0;
`endif
          end
        end
        BUSY: begin
          // A normal release wins over the hold limit on the same edge.
          if (!owner_req) begin
            state_q   <= IDLE;
            gnt_n_q   <= GNT_IDLE[NREQ-1:0];
            gnt_vld_q <= 1'b0;
          end else if (hold_expire) begin
            state_q   <= IDLE;
            gnt_n_q   <= GNT_IDLE[NREQ-1:0];
            gnt_vld_q <= 1'b0;
`ifdef RR_DECODE_ARBITER_TIMEOUT_EN
            timeout_q <= 1'b1;
`endif
          end else begin
`ifdef RR_DECODE_ARBITER_TIMEOUT_EN
            hold_cnt_q <= hold_cnt_q + 1'b1;
`endif
          end
        end
        default: begin
          state_q   <= IDLE;
          gnt_n_q   <= GNT_IDLE[NREQ-1:0];
          gnt_vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_n   = gnt_n_q;
  assign gnt_vld = gnt_vld_q;
  assign gnt_idx = gnt_idx_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Bench for rr_decode_arbiter: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against
// a behavioural model of the round-robin rules.
module tb_rr_decode_arbiter;

  localparam int NREQ     = 16;
  localparam int IDX_W    = 4;
  localparam int MAX_HOLD = 8;
`ifdef RR_DECODE_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  gnt_n;
  logic             gnt_vld;
  logic [IDX_W-1:0] gnt_idx;
  logic             timeout;

  int n_cmp;
  int n_err;

  rr_decode_arbiter #(
    .NREQ     (NREQ),
    .IDX_W    (IDX_W),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .gnt_n   (gnt_n),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit m_busy;
  int m_owner;
  int m_last;
  int m_idx;
  int m_cnt;
  bit m_to;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_owner = 0; m_last = NREQ - 1; m_idx = 0; m_cnt = 0; m_to = 0;
    end else begin
      m_to = 0;
      if (m_busy) begin
        if (!req[m_owner]) m_busy = 0;
        else if (TO_EN && m_cnt == MAX_HOLD - 1) begin
          m_busy = 0; m_to = 1;
        end else m_cnt++;
      end else if (en && req != '0) begin
        for (int k = 1; k <= NREQ; k++) begin
          int c;
          c = (m_last + k) % NREQ;
          if (req[c]) begin
            m_busy = 1; m_owner = c; m_idx = c; m_last = c; m_cnt = 0;
            break;
          end
        end
      end
    end
  end

  function automatic logic [NREQ-1:0] model_gnt_n();
    logic [NREQ-1:0] v;
    v = '1;
    if (m_busy) v[m_owner] = 1'b0;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model plus output invariants.
  always @(negedge clk) begin
    if (rst_n) begin
      check("gnt_n", 32'(gnt_n), 32'(model_gnt_n()));
      check("gnt_vld", 32'(gnt_vld), 32'(m_busy));
      check("gnt_idx", 32'(gnt_idx), 32'(m_idx));
      check("timeout", 32'(timeout), 32'(m_to));
      check("inv_onehot", 32'($countones(~gnt_n) <= 1), 32'd1);
      check("inv_vld", 32'(gnt_vld), 32'(~&gnt_n));
      if (gnt_vld) check("inv_idx_bit", 32'(gnt_n[gnt_idx]), 32'd0);
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; en = 1'b0; req = '0;
    wait_neg(3);
    rst_n = 1'b1;
    wait_neg(1);
    check("rst_gnt_n", 32'(gnt_n), 32'h0000FFFF);
    check("rst_vld", 32'(gnt_vld), 32'd0);
    check("rst_idx", 32'(gnt_idx), 32'd0);

    // Enable gating and en ignored while busy.
    req = 16'h0010; en = 1'b0;
    wait_neg(2);
    check("en0_idle", 32'(gnt_n), 32'h0000FFFF);
    en = 1'b1;
    wait_neg(1);
    check("en1_gnt", 32'(gnt_n), 32'h0000FFEF);
    check("en1_idx", 32'(gnt_idx), 32'd4);
    en = 1'b0;
    wait_neg(3);
    check("en0_busy_hold", 32'(gnt_n), 32'h0000FFEF);
    req = '0;
    wait_neg(1);
    check("rel_vld", 32'(gnt_vld), 32'd0);
    check("rel_idx_kept", 32'(gnt_idx), 32'd4);

    // Single requester: held, then one-cycle drop and re-grant.
    en = 1'b1; req = 16'h0200;
    wait_neg(1);
    check("single_idx", 32'(gnt_idx), 32'd9);
    wait_neg(5);
    check("single_hold", 32'(gnt_n), 32'h0000FDFF);
    req = '0;
    wait_neg(1);
    check("single_gap", 32'(gnt_vld), 32'd0);
    req = 16'h0200;
    wait_neg(1);
    check("single_regnt", 32'(gnt_n), 32'h0000FDFF);
    req = '0;
    wait_neg(1);

    // Wrap-around of the pointer.
    req = 16'h4000;
    wait_neg(1);
    check("wrap_14", 32'(gnt_idx), 32'd14);
    req = '0; wait_neg(1);
    req = 16'h8003; wait_neg(1);
    check("wrap_15", 32'(gnt_idx), 32'd15);
    req = '0; wait_neg(1);
    req = 16'h8003; wait_neg(1);
    check("wrap_0", 32'(gnt_idx), 32'd0);
    req = '0; wait_neg(1);
    req = 16'h8003; wait_neg(1);
    check("wrap_1", 32'(gnt_idx), 32'd1);
    req = '0; wait_neg(1);

    // Asynchronous reset in the middle of a grant.
    req = 16'h0001; wait_neg(1);
    check("pre_rst_gnt", 32'(gnt_n), 32'h0000FFFE);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_gnt", 32'(gnt_n), 32'h0000FFFF);
    check("async_rst_vld", 32'(gnt_vld), 32'd0);
    check("async_rst_idx", 32'(gnt_idx), 32'd0);
    req = 16'h8001;
    @(negedge clk) rst_n = 1'b1;
    wait_neg(1);
    check("post_rst_gnt", 32'(gnt_n), 32'h0000FFFE);

    // Full round robin from a fresh pointer.
    req = '0;
    wait_neg(1);
    rst_n = 1'b0; #1 rst_n = 1'b1;
    req = '1;
    for (int g = 0; g <= NREQ; g++) begin
      wait_neg(1);
      check("rr_vld", 32'(gnt_vld), 32'd1);
      check("rr_idx", 32'(gnt_idx), 32'(g % NREQ));
      wait_neg(2);
      req[gnt_idx] = 1'b0;
      wait_neg(1);
      check("rr_gap", 32'(gnt_vld), 32'd0);
      req = '1;
    end
    req = '0;
    wait_neg(2);

`ifdef RR_DECODE_ARBITER_TIMEOUT_EN
    // Forced release after MAX_HOLD busy cycles.
    req = 16'h0004;
    wait_neg(1);
    check("to_idx", 32'(gnt_idx), 32'd2);
    for (int i = 1; i < MAX_HOLD; i++) begin
      wait_neg(1);
      check("to_hold", 32'(gnt_vld), 32'd1);
    end
    wait_neg(1);
    check("to_rel", 32'(gnt_vld), 32'd0);
    check("to_pulse", 32'(timeout), 32'd1);
    req = 16'h000C;
    wait_neg(1);
    check("to_next", 32'(gnt_idx), 32'd3);
    check("to_pulse_end", 32'(timeout), 32'd0);
    wait_neg(MAX_HOLD - 1);
    req = '0;
    wait_neg(1);
    check("to_same_rel", 32'(gnt_vld), 32'd0);
    check("to_same_pulse", 32'(timeout), 32'd0);
    wait_neg(1);
`endif

    // Randomized traffic checked by the per-cycle comparator.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      en = ($urandom_range(0, 9) != 0);
      for (int b = 0; b < NREQ; b++) begin
        if (m_busy && b == m_owner) begin
          if ($urandom_range(0, 5) == 0) req[b] = 1'b0;
        end else if ($urandom_range(0, 4) == 0) begin
          req[b] = ~req[b];
        end
      end
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    wait_neg(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_decode_arbiter.md
Name: rr_decode_arbiter

Overview:
- Round-robin arbiter sharing one resource among NREQ requesters.
- Grant is presented as an active-low one-hot select: all ones when idle, one bit low when granted. It drives chip-select/enable lines in the same form as the team's 4-to-16 active-low decoder tree.
- Grant is held until the owner drops its request. An enable gates new grants.
- Sits between requester logic and the shared resource's select lines.

Parameters:
- NREQ, 16, number of requesters; power of two, 4..16.
- IDX_W, 4, index width; equals log2(NREQ).
- MAX_HOLD, 255, maximum BUSY cycles before forced release; used only with the optional feature.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  high permits new grants; does not affect a grant already held.
- req  in  NREQ  active-high request per requester; level, held while ownership is wanted.
- gnt_n  out  NREQ  registered active-low one-hot grant; all ones when idle.
- gnt_vld  out  1  registered; high while any grant is held.
- gnt_idx  out  IDX_W  registered index of the current owner; holds its last value when idle.
- timeout  out  1  one-cycle pulse on forced release; constant 0 without the optional feature.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, gnt_n=all ones, gnt_vld=0, gnt_idx=0.
  - last pointer=NREQ-1, so requester 0 has first priority.
- States: IDLE, BUSY.
- IDLE:
  - If en=1 and req!=0, pick the first set req bit searching upward from last+1, wrapping modulo NREQ.
  - Next edge: state=BUSY, gnt_idx=pick, gnt_n[pick]=0 (all other bits 1), gnt_vld=1, last=pick.
  - Latency from req to grant is 1 clock.
  - If en=0 or req=0: remain in IDLE with outputs unchanged.
- BUSY:
  - If req[gnt_idx]=0, next edge: state=IDLE, gnt_n=all ones, gnt_vld=0.
  - Other requests are ignored while BUSY.
  - At least one IDLE cycle separates consecutive grants (bus turnaround). Re-arbitration happens in that IDLE cycle.
  - en falling during BUSY has no effect on the held grant.
- Fairness: after owner k releases, k has lowest priority in the next arbitration. With all NREQ requesting continuously, the grant order is strictly k+1, k+2, … wrapping.
- Wrap-around: if last=NREQ-1, the search starts at 0.
- Single requester: may be re-granted repeatedly; it receives the grant again after its one IDLE gap.
- Simultaneous events: an owner that drops req while a new req arrives in the same cycle is handled by the BUSY→IDLE rule; the new req is considered in the following IDLE cycle.
- Reset mid-grant: gnt_n returns to all ones immediately (async), and the pointer returns to NREQ-1.
- Invariants:
  - gnt_n has at most one 0 bit.
  - gnt_vld = ~&gnt_n.
  - gnt_n bit gnt_idx = ~gnt_vld.
- No combinational path from inputs to any output.

Optional Feature:
- Macro: RR_DECODE_ARBITER_TIMEOUT_EN.
- Defined:
  - A hold counter of width ceil(log2(MAX_HOLD+1)) clears on entry to BUSY and increments each BUSY cycle.
  - When the counter equals MAX_HOLD-1 and req[gnt_idx] is still 1, the next edge forces IDLE (gnt_n all ones, gnt_vld=0) and pulses timeout=1 for exactly that one cycle.
  - The pointer keeps last=owner, so the timed-out owner gets lowest priority.
  - A normal release on the same cycle as timeout takes precedence; timeout stays 0.
- Undefined: no counter is instantiated; timeout is tied 0; a grant is held indefinitely.

Decomposition:
- Package rr_arb_pkg:
  - NREQ/IDX_W defaults.
  - State enum (IDLE, BUSY).
  - GNT_IDLE constant (all ones).
- Sub-module rr_prio_pick: combinational rotating priority encoder.
  - Inputs: req, last.
  - Outputs: pick index, any flag.
- Top level holds the FSM, pointer, registered outputs, and the optional counter. The one-hot active-low gnt_n is decoded from pick in the top level.

Test Plan:
- Reset: rst_n low asynchronously mid-cycle while gnt_n=16'hFFFE → gnt_n=16'hFFFF, gnt_vld=0, gnt_idx=0 before the next edge; after release, req=16'h8001 → grant idx 0 (gnt_n=16'hFFFE).
- Round robin: req=16'hFFFF held; each owner drops req 3 cycles after its grant and reasserts 1 cycle later → gnt_idx sequence 0,1,2,…,15,0, with exactly one IDLE cycle between grants.
- Wrap/pointer: last=14, req=16'h8003 → idx 15; after release, req=16'h8003 → idx 0; then idx 1.
- Enable: en=0 with req=16'h0010 → gnt_n stays 16'hFFFF; en=1 → next edge gnt_n=16'hFFEF, gnt_idx=4; en=0 while BUSY → grant retained until req[4]=0.
- Single requester and invariants: req=16'h0200 held continuously → grant idx 9 persists; drop for 1 cycle → IDLE then re-grant idx 9. Check every cycle: at most one low bit in gnt_n, and gnt_vld=~&gnt_n.
- Timeout (macro defined, MAX_HOLD=8): req=16'h0004 held → grant idx 2 for 8 cycles, forced release, timeout=1 for one cycle; with req=16'h000C, next grant is idx 3. Same-cycle release at count 7 → timeout=0.
